// File: rtl/hacd_pkg.sv
// Shared types and default widths for the HAWK control/scheduling blocks.
package hacd_pkg;

    localparam int HACD_HPPA_W = 48;
    localparam int HACD_PPA_W  = 48;

    typedef enum logic [2:0] {
        INIT,
        ARB,
        LKP_REQ,
        LKP_WAIT,
        TBL_UPD
    } ctrl_sched_state_t;

    typedef struct packed {
        logic                   lookup;
        logic [HACD_HPPA_W-1:0] hppa;
    } att_lkup_reqpkt_t;

    function automatic int clog2_min1(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hawk_rr_arb.sv
// Round-robin search: the first requester at or after ptr_i (wrapping) wins.
module hawk_rr_arb #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int unsigned   pos;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            pos  = (int'(ptr_i) + i) % N;
            cand = IW'(pos);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/hawk_ctrl_sched.sv
// HAWK control scheduler: init sequencing, round-robin CPU channel service,
// one outstanding ATT lookup at a time, per-channel override grant, watchdog.
module hawk_ctrl_sched
    import hacd_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int HPPA_W = HACD_HPPA_W,
    parameter int PPA_W  = HACD_PPA_W,
    parameter int WAY_W  = 32,
    parameter int TO_W   = 16,
    parameter int TO_CYC = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         init_att_done_i,
    input  logic                         init_list_done_i,
    output logic                         init_att_o,
    output logic                         init_list_o,
    input  logic [N_CH-1:0]              req_valid_i,
    input  logic [N_CH*HPPA_W-1:0]       req_hppa_i,
    input  logic                         pgrd_mngr_ready_i,
    output logic                         lkup_valid_o,
    output logic [HPPA_W-1:0]            lkup_hppa_o,
    input  logic                         trnsl_allow_i,
    input  logic [PPA_W-1:0]             trnsl_ppa_i,
    input  logic                         tbl_update_i,
    input  logic [WAY_W-1:0]             tbl_way_i,
    input  logic                         tbl_update_done_i,
    output logic [N_CH-1:0]              ovrd_allow_o,
    output logic [N_CH*PPA_W-1:0]        ovrd_ppa_o,
    output logic [clog2_min1(N_CH)-1:0]  cur_ch_o,
    output logic                         busy_o,
    output logic                         timeout_err_o
);

    localparam int CH_W = clog2_min1(N_CH);

    ctrl_sched_state_t            state_q, state_d;
    logic                         init_att_q, init_att_d, init_list_q, init_list_d;
    att_lkup_reqpkt_t             lkup_q, lkup_d;   // HPPA_W must not exceed HACD_HPPA_W
    logic [N_CH-1:0]              allow_q, allow_d;
    logic [N_CH-1:0][PPA_W-1:0]   ppa_q, ppa_d;
    logic [CH_W-1:0]              cur_q, cur_d, ptr_q, ptr_d, next_ch;
    logic                         busy_q, to_err_q, to_err_d, svc_end;
    logic [TO_W-1:0]              wdog_q, wdog_d;
    logic                         wd_expire;

    logic [N_CH-1:0][HPPA_W-1:0]  hppa_arr;
    logic [HPPA_W-1:0]            arb_hppa;
    logic [N_CH-1:0]              arb_gnt;
    logic [CH_W-1:0]              arb_idx;
    logic                         arb_any;

    assign hppa_arr = req_hppa_i;

    hawk_rr_arb #(.N(N_CH), .IW(CH_W)) u_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        arb_hppa = '0;
        for (int c = 0; c < N_CH; c++) begin
            arb_hppa = arb_hppa | (hppa_arr[c] & {HPPA_W{arb_gnt[c]}});
        end
    end

    assign wd_expire = (wdog_q == TO_W'(TO_CYC - 1));
    assign next_ch   = (cur_q == CH_W'(N_CH - 1)) ? '0 : cur_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        init_att_d  = init_att_q;
        init_list_d = init_list_q;
        lkup_d      = lkup_q;
        allow_d     = '0;
        ppa_d       = ppa_q;
        cur_d       = cur_q;
        ptr_d       = ptr_q;
        to_err_d    = to_err_q;
        wdog_d      = wdog_q;
        svc_end     = 1'b0;
        case (state_q)
            INIT: begin
                if (init_att_done_i) init_att_d = 1'b0;
                if (init_list_done_i) begin
                    init_list_d = 1'b0;
                    state_d     = ARB;
                end
            end
            ARB: begin
                if (arb_any) begin
                    cur_d       = arb_idx;
                    lkup_d.hppa = HACD_HPPA_W'(arb_hppa);
                    state_d     = LKP_REQ;
                end
            end
            LKP_REQ: begin
                if (pgrd_mngr_ready_i) begin
                    lkup_d.lookup = 1'b1;
                    wdog_d        = '0;
                    state_d       = LKP_WAIT;
                end
            end
            LKP_WAIT, TBL_UPD: begin
                wdog_d = (&wdog_q) ? wdog_q : wdog_q + 1'b1;
                // Completion is checked before expiry so a last-cycle answer still grants.
                if (state_q == LKP_WAIT && trnsl_allow_i) begin
                    ppa_d[cur_q]   = trnsl_ppa_i;
                    allow_d[cur_q] = 1'b1;
                    svc_end        = 1'b1;
                end else if (state_q == LKP_WAIT && tbl_update_i) begin
                    ppa_d[cur_q] = PPA_W'(tbl_way_i);
                    state_d      = TBL_UPD;
                end else if (state_q == TBL_UPD && tbl_update_done_i) begin
                    allow_d[cur_q] = 1'b1;
                    svc_end        = 1'b1;
                end else if (wd_expire) begin
                    to_err_d = 1'b1;
                    svc_end  = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
        if (svc_end) begin
            lkup_d  = '0;
            ptr_d   = next_ch;
            state_d = ARB;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            init_att_q  <= 1'b1;
            init_list_q <= 1'b1;
            lkup_q      <= '0;
            allow_q     <= '0;
            ppa_q       <= '0;
            cur_q       <= '0;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            to_err_q    <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            init_att_q  <= init_att_d;
            init_list_q <= init_list_d;
            lkup_q      <= lkup_d;
            allow_q     <= allow_d;
            ppa_q       <= ppa_d;
            cur_q       <= cur_d;
            ptr_q       <= ptr_d;
            // Busy means a channel is being served; INIT counts as idle.
            busy_q      <= (state_d == LKP_REQ) || (state_d == LKP_WAIT) || (state_d == TBL_UPD);
            to_err_q    <= to_err_d;
            wdog_q      <= wdog_d;
        end
    end

    assign init_att_o    = init_att_q;
    assign init_list_o   = init_list_q;
    assign lkup_valid_o  = lkup_q.lookup;
    assign lkup_hppa_o   = lkup_q.hppa[HPPA_W-1:0];
    assign ovrd_allow_o  = allow_q;
    assign ovrd_ppa_o    = ppa_q;
    assign cur_ch_o      = cur_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = to_err_q;

endmodule

// File: tb/tb_hawk_ctrl_sched.sv
// Randomized scoreboard bench for hawk_ctrl_sched (4 channels, 16-cycle watchdog).
module tb_hawk_ctrl_sched;

    localparam int N = 4, HW = 48, PW = 48, WW = 32, TOW = 16, TOC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_ni = 1'b0, att_done = 1'b0, list_done = 1'b0;
    logic              init_att, init_list;
    logic [N-1:0]      req_valid = '0;
    logic [N*HW-1:0]   req_hppa = '0;
    logic              ready = 1'b0, trnsl_allow = 1'b0, tbl_update = 1'b0, tbl_done = 1'b0;
    logic [PW-1:0]     trnsl_ppa = '0;
    logic [WW-1:0]     tbl_way = '0;
    logic              lkup_valid, busy, to_err;
    logic [HW-1:0]     lkup_hppa;
    logic [N-1:0]      ovrd_allow;
    logic [N*PW-1:0]   ovrd_ppa;
    logic [1:0]        cur_ch;

    hawk_ctrl_sched #(.N_CH(N), .HPPA_W(HW), .PPA_W(PW), .WAY_W(WW), .TO_W(TOW), .TO_CYC(TOC)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .init_att_done_i(att_done), .init_list_done_i(list_done),
        .init_att_o(init_att), .init_list_o(init_list),
        .req_valid_i(req_valid), .req_hppa_i(req_hppa),
        .pgrd_mngr_ready_i(ready), .lkup_valid_o(lkup_valid), .lkup_hppa_o(lkup_hppa),
        .trnsl_allow_i(trnsl_allow), .trnsl_ppa_i(trnsl_ppa),
        .tbl_update_i(tbl_update), .tbl_way_i(tbl_way), .tbl_update_done_i(tbl_done),
        .ovrd_allow_o(ovrd_allow), .ovrd_ppa_o(ovrd_ppa), .cur_ch_o(cur_ch),
        .busy_o(busy), .timeout_err_o(to_err)
    );

    typedef struct { int ch; logic [HW-1:0] hppa; } lk_t;
    typedef struct { int ch; bit allow; logic [PW-1:0] ppa; bit to; longint at; } cp_t;

    lk_t lq[$];
    cp_t cq[$];
    int n_cmp = 0, n_err = 0;
    longint cyc = 0;
    bit pend[N];
    logic [HW-1:0] m_hppa[N];
    logic [PW-1:0] m_ppa[N];
    int m_ptr = 0;
    bit m_to = 1'b0, mon_en = 1'b0, abort = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference arbitration: first pending channel at or after the pointer.
    function automatic int pick();
        for (int i = 0; i < N; i++) if (pend[(m_ptr + i) % N]) return (m_ptr + i) % N;
        return 0;
    endfunction

    // Monitor: lookup rise pops the lookup queue, lookup fall pops the completion queue.
    logic lv_prev = 1'b0;
    lk_t  me;
    cp_t  mc;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!lv_prev && lkup_valid) begin
                if (lq.size() == 0) chk("lkup_unexpected", 64'(lkup_valid), 64'd0);
                else begin
                    me = lq.pop_front();
                    chk("lkup_hppa", 64'(lkup_hppa), 64'(me.hppa));
                    chk("lkup_ch", 64'(cur_ch), 64'(me.ch));
                    chk("busy_serving", 64'(busy), 64'd1);
                end
            end
            if (lv_prev && !lkup_valid) begin
                if (cq.size() == 0) chk("cmpl_unexpected", 64'(lv_prev), 64'd0);
                else begin
                    mc = cq.pop_front();
                    chk("cmpl_cycle", 64'(cyc), 64'(mc.at));
                    chk("ovrd_allow", 64'(ovrd_allow), mc.allow ? (64'd1 << mc.ch) : 64'd0);
                    chk("ovrd_ppa", 64'(ovrd_ppa[mc.ch*PW +: PW]), 64'(mc.ppa));
                    chk("timeout_err", 64'(to_err), 64'(mc.to));
                    chk("lkup_hppa_drop", 64'(lkup_hppa), 64'd0);
                    chk("busy_idle", 64'(busy), 64'd0);
                end
            end else if (ovrd_allow != '0) begin
                chk("spurious_allow", 64'(ovrd_allow), 64'd0);
            end
        end
        lv_prev = lkup_valid;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_reqs();
        for (int c = 0; c < N; c++) begin
            req_valid[c] = pend[c];
            req_hppa[c*HW +: HW] = m_hppa[c];
        end
    endtask

    // kind: 0 hit, 1 alloc, 2 no response; mode: 0 keep, 1 random add, 2 all pending
    task automatic do_txn(int kind, int mode);
        int ch, d, k, n;
        bit any;
        logic [PW-1:0] p;
        logic [WW-1:0] w;
        longint c0;
        if (abort) return;
        any = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (!pend[c] && (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0))) begin
                pend[c] = 1'b1;
                m_hppa[c] = HW'({$urandom, $urandom});
            end
            any |= pend[c];
        end
        if (!any) begin
            k = $urandom_range(0, N - 1);
            pend[k] = 1'b1;
            m_hppa[k] = HW'({$urandom, $urandom});
        end
        drive_reqs();
        ch = pick();
        lq.push_back('{ch, m_hppa[ch]});
        n = 0;
        do begin
            ready = ($urandom_range(0, 2) != 0);
            tick();
            n++;
        end while (!lkup_valid && n < 40);
        if (!lkup_valid) begin
            chk("lkup_issue_timeout", 64'(lkup_valid), 64'd1);
            abort = 1'b1;
            return;
        end
        ready = 1'b0;
        c0 = cyc;
        case (kind)
            0: begin
                d = ($urandom_range(0, 4) == 0) ? TOC - 1 : $urandom_range(0, 3);
                repeat (d) tick();
                p = PW'({$urandom, $urandom});
                trnsl_allow = 1'b1;
                trnsl_ppa = p;
                if ($urandom_range(0, 2) == 0) begin
                    tbl_update = 1'b1;
                    tbl_way = $urandom;
                end
                m_ppa[ch] = p;
                m_ptr = (ch + 1) % N;
                cq.push_back('{ch, 1'b1, p, m_to, cyc + 1});
                tick();
                trnsl_allow = 1'b0;
                tbl_update = 1'b0;
            end
            1: begin
                d = $urandom_range(0, 3);
                repeat (d) tick();
                w = $urandom;
                tbl_update = 1'b1;
                tbl_way = w;
                tbl_done = 1'($urandom_range(0, 1));
                tick();
                tbl_update = 1'b0;
                tbl_done = 1'b0;
                k = $urandom_range(0, 8);
                repeat (k) tick();
                tbl_done = 1'b1;
                m_ppa[ch] = PW'(w);
                m_ptr = (ch + 1) % N;
                cq.push_back('{ch, 1'b1, PW'(w), m_to, cyc + 1});
                tick();
                tbl_done = 1'b0;
            end
            default: begin
                m_to = 1'b1;
                m_ptr = (ch + 1) % N;
                cq.push_back('{ch, 1'b0, m_ppa[ch], 1'b1, c0 + TOC});
            end
        endcase
        n = 0;
        while (lkup_valid && n < 40) begin
            tick();
            n++;
        end
        if (lkup_valid) begin
            chk("lkup_drop_timeout", 64'(lkup_valid), 64'd0);
            abort = 1'b1;
            return;
        end
        if (kind != 2) begin
            pend[ch] = 1'b0;
            req_valid[ch] = 1'b0;
        end
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_init_att"}, 64'(init_att), 64'd1);
        chk({tag, "_init_list"}, 64'(init_list), 64'd1);
        chk({tag, "_lkup_valid"}, 64'(lkup_valid), 64'd0);
        chk({tag, "_lkup_hppa"}, 64'(lkup_hppa), 64'd0);
        chk({tag, "_allow"}, 64'(ovrd_allow), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_to_err"}, 64'(to_err), 64'd0);
        chk({tag, "_cur_ch"}, 64'(cur_ch), 64'd0);
        for (int c = 0; c < N; c++) chk({tag, "_ppa"}, 64'(ovrd_ppa[c*PW +: PW]), 64'd0);
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            pend[c] = 1'b0; m_hppa[c] = '0; m_ppa[c] = '0;
        end
        repeat (2) tick();
        chk_reset_state("rst");
        rst_ni = 1'b1;
        repeat (2) tick();
        chk("init_hold_att", 64'(init_att), 64'd1);
        att_done = 1'b1;
        tick();
        att_done = 1'b0;
        chk("init_att_clr", 64'(init_att), 64'd0);
        chk("init_list_held", 64'(init_list), 64'd1);
        tick();
        list_done = 1'b1;
        tick();
        list_done = 1'b0;
        chk("init_list_clr", 64'(init_list), 64'd0);
        repeat (2) tick();
        chk("arb_idle_busy", 64'(busy), 64'd0);
        chk("arb_idle_lkup", 64'(lkup_valid), 64'd0);
        mon_en = 1'b1;

        // All channels held: service must rotate 0,1,2,3,0
        for (int i = 0; i < 5; i++) do_txn(0, 2);
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 99);
            do_txn((r < 45) ? 0 : (r < 85) ? 1 : 2, 1);
        end

        // Reset while inside a table update
        if (!abort) begin
            pend[2] = 1'b1;
            m_hppa[2] = HW'({$urandom, $urandom});
            drive_reqs();
            lq.push_back('{pick(), m_hppa[pick()]});
            ready = 1'b1;
            for (int n = 0; n < 40 && !lkup_valid; n++) tick();
            ready = 1'b0;
            tbl_update = 1'b1;
            tbl_way = $urandom;
            tick();
            tbl_update = 1'b0;
            mon_en = 1'b0;
            rst_ni = 1'b0;
            tick();
            rst_ni = 1'b1;
            for (int c = 0; c < N; c++) begin
                pend[c] = 1'b0; m_ppa[c] = '0;
            end
            req_valid = '0;
            m_ptr = 0;
            m_to = 1'b0;
            lq.delete();
            cq.delete();
            chk_reset_state("midrst");
            tbl_done = 1'b1;
            tick();
            tbl_done = 1'b0;
            chk("midrst_no_grant", 64'(ovrd_allow), 64'd0);
            att_done = 1'b1;
            list_done = 1'b1;
            tick();
            att_done = 1'b0;
            list_done = 1'b0;
            chk("reinit_att", 64'(init_att), 64'd0);
            chk("reinit_list", 64'(init_list), 64'd0);
            chk("reinit_allow", 64'(ovrd_allow), 64'd0);
            mon_en = 1'b1;
        end
        for (int i = 0; i < 15; i++) begin
            int r;
            r = $urandom_range(0, 99);
            do_txn((r < 45) ? 0 : (r < 85) ? 1 : 2, 1);
        end
        repeat (3) tick();
        chk("scoreboard_drained", 64'(lq.size() + cq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
